// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and converter state encoding.
package bcd_pkg;
    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int ADJ_THRESH    = 8;
    localparam int ADJ_VALUE     = 3;
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;
endpackage

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: start/busy/done handshake and data bus of the BCD-to-binary converter.
interface bcd2bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [WIDTH-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;
    modport master (output start, bcd_in, input bin_out, busy, done, err);
    modport slave  (input start, bcd_in, output bin_out, busy, done, err);
endinterface

// File: rtl/bcd_nib_adj.sv
// bcd_nib_adj: per-digit double-dabble correction; subtract variant by default, add variant for bin-to-BCD.
module bcd_nib_adj
    import bcd_pkg::*;
#(
    parameter int THRESH = ADJ_THRESH,
    parameter int VALUE  = ADJ_VALUE,
    parameter bit SUB    = 1'b1
) (
    input  logic [BCD_DIGIT_W-1:0] nib_i,
    output logic [BCD_DIGIT_W-1:0] nib_o
);
    always_comb begin
        nib_o = (nib_i >= BCD_DIGIT_W'(THRESH))
              ? (SUB ? nib_i - BCD_DIGIT_W'(VALUE) : nib_i + BCD_DIGIT_W'(VALUE))
              : nib_i;
    end
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: iterative reverse double-dabble, one shift/correct step per clock, WIDTH steps per result.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd2bin_seq_if.slave bus_if
);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int RW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state_q;
    logic [RW-1:0]   work_q;
    logic [RW-1:0]   work_sh;
    logic [RW-1:0]   work_d;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] bin_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            valid;

    assign work_sh             = work_q >> 1;
    assign work_d[WIDTH-1:0]   = work_sh[WIDTH-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nib_adj u_adj (
            .nib_i(work_sh[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .nib_o(work_d[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        valid = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            valid = valid & (bus_if.bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] <= BCD_DIGIT_W'(BCD_MAX_DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_if.start && valid) begin
                        work_q  <= {bus_if.bcd_in, {WIDTH{1'b0}}};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end else if (bus_if.start) begin
                        err_q <= 1'b1;
                    end
                end
                CONV: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    // the last shift lands the full binary value in the low field
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bin_q   <= work_d[WIDTH-1:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.bin_out = bin_q;
    assign bus_if.busy    = busy_q;
    assign bus_if.done    = done_q;
    assign bus_if.err     = err_q;
endmodule
